// File: rtl/npc_fleet.sv
// npc_fleet: multi-car NPC traffic engine, advanced once per frame_clk edge.
//   frame_clk  : sole clock, one update per video frame
//   reset      : asynchronous, active-low
//   keycode    : keyboard code; START_KEY arms the fleet
//   randnum    : per-frame random value (spawn x, direction, speed)
//   hit_mask   : per-slot kill request from the collision unit
//   npc_x/y    : packed per-slot position, slot i at [10i+9:10i]
//   npc_active : per-slot valid
//   spawn_pulse: high for the edge on which a car spawned
module npc_fleet #(
  parameter int unsigned N_CARS       = 4,
  parameter int unsigned X_MIN        = 48,
  parameter int unsigned X_MAX        = 232,
  parameter int unsigned Y_MAX        = 238,
  parameter int unsigned RAND_W       = 8,
  parameter int unsigned SPEED_W      = 2,
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter logic [7:0]  START_KEY    = 8'h15
) (
  input  logic                     frame_clk,
  input  logic                     reset,
  input  logic [7:0]               keycode,
  input  logic [RAND_W-1:0]        randnum,
  input  logic [N_CARS-1:0]        hit_mask,
  output logic [10*N_CARS-1:0]     npc_x,
  output logic [10*N_CARS-1:0]     npc_y,
  output logic [N_CARS-1:0]        npc_active,
  output logic                     spawn_pulse
);

  localparam int unsigned TW    = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned IDX_W = (N_CARS > 1) ? $clog2(N_CARS) : 1;
  localparam int unsigned SP_W  = SPEED_W + 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SPAWN_PERIOD - 1);
  localparam logic [9:0]    X_MIN_V = 10'(X_MIN);
  localparam logic [9:0]    X_MAX_V = 10'(X_MAX);

  logic                          started_q, started_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [N_CARS-1:0]             active_q, active_d;
  logic [N_CARS-1:0]             dir_q, dir_d;
  logic [N_CARS-1:0][9:0]        x_q, x_d;
  logic [N_CARS-1:0][9:0]        y_q, y_d;
  logic [N_CARS-1:0][SP_W-1:0]   speed_q, speed_d;
  logic                          spawn_pulse_q, spawn_pulse_d;

  logic [9:0]       rand_ext;
  logic [9:0]       spawn_x;
  logic [SP_W-1:0]  spawn_speed;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             do_spawn;

  // Fold randnum into the road span by reflecting off the right wall / shifting past the left.
  always_comb begin
    rand_ext    = 10'(randnum);
    spawn_x     = rand_ext;
    if (rand_ext > X_MAX_V) begin
      spawn_x = 10'(2 * X_MAX) - rand_ext;
    end else if (rand_ext < X_MIN_V) begin
      spawn_x = rand_ext + X_MIN_V;
    end
    spawn_speed = SP_W'(randnum[SPEED_W:1]) + SP_W'(1);
  end

  // Lowest-index free slot, judged on pre-edge state so a slot freed this edge waits one edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_CARS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    do_spawn = started_q && (timer_q == '0) && free_found;
  end

  // Next-state: arming, spawn timer, per-slot spawn / hit / motion.
  always_comb begin
    started_d     = started_q | (keycode == START_KEY);
    timer_d       = timer_q;
    active_d      = active_q;
    dir_d         = dir_q;
    x_d           = x_q;
    y_d           = y_q;
    speed_d       = speed_q;
    spawn_pulse_d = do_spawn;

    // Timer parks at zero while every slot is busy, giving a retry on each edge.
    if (started_q) begin
      if (timer_q == '0) begin
        if (free_found) begin
          timer_d = TIMER_RELOAD;
        end
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end

    for (int i = 0; i < N_CARS; i++) begin
      if (do_spawn && (free_idx == IDX_W'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = spawn_x;
        y_d[i]      = 10'd0;
        dir_d[i]    = randnum[0];
        speed_d[i]  = spawn_speed;
      end else if (started_q && active_q[i]) begin
        if (hit_mask[i]) begin
          active_d[i] = 1'b0;
        end else if ((11'(y_q[i]) + 11'(speed_q[i])) > 11'(Y_MAX)) begin
          active_d[i] = 1'b0;
        end else begin
          y_d[i] = y_q[i] + 10'(speed_q[i]);
          // Reflection happens in the same frame as the wall contact.
          if (dir_q[i] && (x_q[i] >= X_MAX_V)) begin
            dir_d[i] = 1'b0;
            x_d[i]   = x_q[i] - 10'd1;
          end else if (!dir_q[i] && (x_q[i] <= X_MIN_V)) begin
            dir_d[i] = 1'b1;
            x_d[i]   = x_q[i] + 10'd1;
          end else if (dir_q[i]) begin
            x_d[i]   = x_q[i] + 10'd1;
          end else begin
            x_d[i]   = x_q[i] - 10'd1;
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge frame_clk or negedge reset) begin
    if (!reset) begin
      started_q     <= 1'b0;
      timer_q       <= TIMER_RELOAD;
      active_q      <= '0;
      dir_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      speed_q       <= '0;
      spawn_pulse_q <= 1'b0;
    end else begin
      started_q     <= started_d;
      timer_q       <= timer_d;
      active_q      <= active_d;
      dir_q         <= dir_d;
      x_q           <= x_d;
      y_q           <= y_d;
      speed_q       <= speed_d;
      spawn_pulse_q <= spawn_pulse_d;
    end
  end

  assign npc_x       = x_q;
  assign npc_y       = y_q;
  assign npc_active  = active_q;
  assign spawn_pulse = spawn_pulse_q;

endmodule

// File: tb/tb_npc_fleet.sv
// Self-checking bench for npc_fleet: reference model feeds a scoreboard queue,
// plus directed checks on spawn fold, wall bounce, despawn, pending spawn, hit and async reset.
module tb_npc_fleet;

  localparam int N    = 4;
  localparam int PER  = 4;
  localparam int XMIN = 48;
  localparam int XMAX = 232;
  localparam int YMAX = 238;

  logic              frame_clk;
  logic              reset;
  logic [7:0]        keycode;
  logic [7:0]        randnum;
  logic [N-1:0]      hit_mask;
  logic [10*N-1:0]   npc_x;
  logic [10*N-1:0]   npc_y;
  logic [N-1:0]      npc_active;
  logic              spawn_pulse;

  npc_fleet #(
    .N_CARS(N), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MAX(YMAX),
    .RAND_W(8), .SPEED_W(2), .SPAWN_PERIOD(PER), .START_KEY(8'h15)
  ) dut (
    .frame_clk  (frame_clk),
    .reset      (reset),
    .keycode    (keycode),
    .randnum    (randnum),
    .hit_mask   (hit_mask),
    .npc_x      (npc_x),
    .npc_y      (npc_y),
    .npc_active (npc_active),
    .spawn_pulse(spawn_pulse)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [10*N-1:0] x;
    logic [10*N-1:0] y;
    logic [N-1:0]    act;
    logic            pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state.
  bit m_started;
  int m_timer;
  bit m_act[N];
  bit m_dir[N];
  int m_x[N];
  int m_y[N];
  int m_spd[N];
  bit m_pulse;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int fold(input int r);
    if (r > XMAX) return 2 * XMAX - r;
    if (r < XMIN) return r + XMIN;
    return r;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_timer   = PER - 1;
    m_pulse   = 0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] k, input logic [7:0] r, input logic [N-1:0] h);
    int slot;
    int yn;
    slot    = -1;
    m_pulse = 0;
    if (m_started) begin
      for (int i = 0; i < N; i++) if (!m_act[i] && slot < 0) slot = i;
      if (m_timer != 0) begin
        m_timer = m_timer - 1;
        slot    = -1;
      end else if (slot >= 0) begin
        m_timer = PER - 1;
      end
      for (int i = 0; i < N; i++) begin
        if (i == slot) continue;
        if (!m_act[i]) continue;
        if (h[i]) begin
          m_act[i] = 0;
          continue;
        end
        yn = m_y[i] + m_spd[i];
        if (yn > YMAX) begin
          m_act[i] = 0;
          continue;
        end
        m_y[i] = yn;
        if (m_dir[i]) begin
          if (m_x[i] >= XMAX) begin m_dir[i] = 0; m_x[i]--; end
          else m_x[i]++;
        end else begin
          if (m_x[i] <= XMIN) begin m_dir[i] = 1; m_x[i]++; end
          else m_x[i]--;
        end
      end
      if (slot >= 0) begin
        m_act[slot] = 1;
        m_x[slot]   = fold(int'(r));
        m_y[slot]   = 0;
        m_dir[slot] = r[0];
        m_spd[slot] = int'(r[2:1]) + 1;
        m_pulse     = 1;
      end
    end
    if (k == 8'h15) m_started = 1;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.x[10*i +: 10] = 10'(m_x[i]);
      e.y[10*i +: 10] = 10'(m_y[i]);
      e.act[i]        = m_act[i];
    end
    e.pulse = m_pulse;
    return e;
  endfunction

  // One frame: drive on negedge, queue the model's expectation, compare just after the edge.
  task automatic step(input logic [7:0] k, input logic [7:0] r, input logic [N-1:0] h);
    exp_t e;
    @(negedge frame_clk);
    keycode  = k;
    randnum  = r;
    hit_mask = h;
    model_step(k, r, h);
    exp_q.push_back(snapshot());
    @(posedge frame_clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_x",     64'(npc_x),       64'(e.x));
      check("sb_y",     64'(npc_y),       64'(e.y));
      check("sb_act",   64'(npc_active),  64'(e.act));
      check("sb_pulse", 64'(spawn_pulse), 64'(e.pulse));
    end
  endtask

  function automatic logic [9:0] xs(input int i);
    return npc_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] ys(input int i);
    return npc_y[10*i +: 10];
  endfunction

  logic [7:0] r;
  logic [N-1:0] h;

  initial begin
    reset    = 1'b0;
    keycode  = 8'h00;
    randnum  = 8'h00;
    hit_mask = '0;
    model_reset();
    #1;
    check("rst_act",   64'(npc_active),  64'd0);
    check("rst_x",     64'(npc_x),       64'd0);
    check("rst_pulse", 64'(spawn_pulse), 64'd0);
    @(negedge frame_clk);
    reset = 1'b1;

    // Not armed: nothing may spawn.
    for (int j = 0; j < 6; j++) step(8'h00, 8'(($urandom)), '0);
    step(8'h15, 8'h33, '0);
    for (int j = 0; j < 3; j++) step(8'h00, 8'(($urandom)), '0);
    step(8'h00, 8'hF5, '0);
    check("spawn0_act",   64'(npc_active[0]), 64'd1);
    check("spawn0_x",     64'(xs(0)),         64'd219);
    check("spawn0_y",     64'(ys(0)),         64'd0);
    check("spawn0_pulse", 64'(spawn_pulse),   64'd1);

    // Low speed bits forced to keep every later car at speed 1 for a predictable timeline.
    for (int t = 1; t <= 85; t++) begin
      r = (t == 4) ? 8'h10 : (8'($urandom) & 8'hF9);
      h = (t == 82) ? 4'b0100 : (t == 83) ? 4'b0101 : 4'b0000;
      step(8'h00, r, h);
      case (t)
        4:  begin
              check("spawn1_x",   64'(xs(1)),         64'd64);
              check("spawn1_act", 64'(npc_active[1]), 64'd1);
            end
        13: check("bounce_r_hit",  64'(xs(0)), 64'd232);
        14: check("bounce_r_back", 64'(xs(0)), 64'd231);
        20: check("bounce_l_hit",  64'(xs(1)), 64'd48);
        21: check("bounce_l_back", 64'(xs(1)), 64'd49);
        40: check("pending_nopulse", 64'(spawn_pulse), 64'd0);
        80: begin
              check("despawn_act",   64'(npc_active[0]), 64'd0);
              check("despawn_y",     64'(ys(0)),         64'd237);
              check("despawn_noreuse", 64'(spawn_pulse), 64'd0);
            end
        81: begin
              check("reuse_act",   64'(npc_active[0]), 64'd1);
              check("reuse_y",     64'(ys(0)),         64'd0);
              check("reuse_pulse", 64'(spawn_pulse),   64'd1);
            end
        83: check("hit_mask", 64'(npc_active), 64'h0A);
        85: check("three_active", 64'(npc_active), 64'h0B);
        default: ;
      endcase
    end

    // Asynchronous reset between edges with three cars on the road.
    #2;
    reset = 1'b0;
    #1;
    check("async_act",   64'(npc_active),  64'd0);
    check("async_x",     64'(npc_x),       64'd0);
    check("async_y",     64'(npc_y),       64'd0);
    check("async_pulse", 64'(spawn_pulse), 64'd0);
    model_reset();
    @(negedge frame_clk);
    reset = 1'b1;

    // Re-arm and run with unconstrained randomness and random hits.
    step(8'h15, 8'(($urandom)), '0);
    for (int j = 0; j < 120; j++) begin
      r = 8'($urandom);
      h = (($urandom % 4) == 0) ? N'($urandom) : '0;
      step((($urandom % 16) == 0) ? 8'h15 : 8'h00, r, h);
    end

    if (exp_q.size() != 0) check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
